// File: rtl/axi_pkg.sv
// Shared constants and FSM state encodings for the AXI backing-memory slave.
package axi_pkg;

   localparam int unsigned AXI_DATA_WIDTH = 64;
   localparam int unsigned AXI_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_WAIT = 2'd1,
      RD_SEND = 2'd2
   } rd_state_t;

   typedef enum logic [0:0] {
      WR_IDLE = 1'b0,
      WR_DATA = 1'b1
   } wr_state_t;

endpackage

// File: rtl/mem_sp_ram.sv
// Word-addressed RAM: one synchronous write port, one combinational read port.
module mem_sp_ram #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned DEPTH_LOG2 = 14
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [DATA_W-1:0]     o_rdata_c
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Storage write; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/axi_burst_mem_slave.sv
// Fixed-length wrapping-burst AXI responder backed by an internal RAM.
module axi_burst_mem_slave
   import axi_pkg::*;
#(
   parameter int unsigned       ADDR_W     = AXI_ADDR_WIDTH,
   parameter int unsigned       DATA_W     = AXI_DATA_WIDTH,
   parameter int unsigned       BEATS      = 4,
   parameter int unsigned       DEPTH_LOG2 = 14,
   parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(32'h8000_0000),
   parameter int unsigned       RD_LAT     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ar_addr,
   input  logic              ar_valid,
   output logic              ar_ready,
   output logic              r_valid,
   input  logic              r_ready,
   output logic [DATA_W-1:0] r_data,
   input  logic [ADDR_W-1:0] aw_addr,
   input  logic              aw_valid,
   output logic              aw_ready,
   input  logic [DATA_W-1:0] w_data,
   input  logic              w_valid,
   output logic              w_ready,
   output logic              r_last,
   output logic              addr_err
);

   localparam int unsigned BEAT_W = $clog2(BEATS);
   localparam int unsigned LAT_W  = 4;
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(8) << DEPTH_LOG2;

   // Beat k of a line-wrapping burst: keep the line bits, wrap the beat bits.
   function automatic logic [DEPTH_LOG2-1:0] beat_idx(input logic [DEPTH_LOG2-1:0] s,
                                                       input logic [BEAT_W-1:0]     k);
      return {s[DEPTH_LOG2-1:BEAT_W], BEAT_W'(s[BEAT_W-1:0] + k)};
   endfunction

   rd_state_t               r_rd_state, w_rd_state_nxt;
   wr_state_t               r_wr_state, w_wr_state_nxt;
   logic [LAT_W-1:0]        r_lat_cnt, w_lat_nxt;
   logic [BEAT_W-1:0]       r_rd_beat, w_rd_beat_nxt, w_ld_beat;
   logic [BEAT_W-1:0]       r_wr_beat, w_wr_beat_nxt;
   logic [DEPTH_LOG2-1:0]   r_rd_idx, r_wr_idx, w_rd_raddr, w_wr_addr;
   logic                    r_rd_ok, r_wr_ok;
   logic                    w_rd_load, w_we, w_ar_hs, w_aw_hs, w_ar_ok, w_aw_ok;
   logic [ADDR_W-1:0]       w_ar_off, w_aw_off;
   logic [DATA_W-1:0]       w_ram_rdata, w_rd_word;

   assign w_ar_hs  = ar_valid && ar_ready;
   assign w_aw_hs  = aw_valid && aw_ready;
   assign w_ar_off = ar_addr - BASE;
   assign w_aw_off = aw_addr - BASE;
   assign w_ar_ok  = {1'b0, w_ar_off} < SPAN;
   assign w_aw_ok  = {1'b0, w_aw_off} < SPAN;

   assign w_rd_raddr = beat_idx(r_rd_idx, w_ld_beat);
   assign w_wr_addr  = beat_idx(r_wr_idx, r_wr_beat);

   // Write-first: a same-edge write to the word being loaded bypasses the RAM.
   assign w_rd_word = !r_rd_ok                              ? '0      :
                      (w_we && (w_wr_addr == w_rd_raddr))   ? w_data  : w_ram_rdata;

   mem_sp_ram #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk       (clk),
      .i_we      (w_we),
      .i_waddr   (w_wr_addr),
      .i_wdata   (w_data),
      .i_raddr   (w_rd_raddr),
      .o_rdata_c (w_ram_rdata)
   );

   // Read FSM next state, latency countdown and beat-load selection.
   always_comb begin
      w_rd_state_nxt = r_rd_state;
      w_lat_nxt      = r_lat_cnt;
      w_rd_beat_nxt  = r_rd_beat;
      w_rd_load      = 1'b0;
      w_ld_beat      = '0;
      case (r_rd_state)
         RD_IDLE: begin
            if (w_ar_hs) begin
               w_rd_state_nxt = RD_WAIT;
               w_lat_nxt      = LAT_W'(RD_LAT - 1);
               w_rd_beat_nxt  = '0;
            end
         end
         RD_WAIT: begin
            if (r_lat_cnt == '0) begin
               w_rd_state_nxt = RD_SEND;
               w_rd_load      = 1'b1;
            end else begin
               w_lat_nxt = r_lat_cnt - LAT_W'(1);
            end
         end
         RD_SEND: begin
            if (r_valid && r_ready) begin
               if (r_rd_beat == BEAT_W'(BEATS - 1)) begin
                  w_rd_state_nxt = RD_IDLE;
               end else begin
                  w_rd_beat_nxt = r_rd_beat + BEAT_W'(1);
                  w_ld_beat     = r_rd_beat + BEAT_W'(1);
                  w_rd_load     = 1'b1;
               end
            end
         end
         default: w_rd_state_nxt = RD_IDLE;
      endcase
   end

   // Write FSM next state and RAM write enable (out-of-range beats dropped).
   always_comb begin
      w_wr_state_nxt = r_wr_state;
      w_wr_beat_nxt  = r_wr_beat;
      w_we           = 1'b0;
      case (r_wr_state)
         WR_IDLE: begin
            if (w_aw_hs) begin
               w_wr_state_nxt = WR_DATA;
               w_wr_beat_nxt  = '0;
            end
         end
         WR_DATA: begin
            if (w_valid && w_ready) begin
               w_we = r_wr_ok;
               if (r_wr_beat == BEAT_W'(BEATS - 1)) begin
                  w_wr_state_nxt = WR_IDLE;
               end else begin
                  w_wr_beat_nxt = r_wr_beat + BEAT_W'(1);
               end
            end
         end
         default: w_wr_state_nxt = WR_IDLE;
      endcase
   end

   // Read-side state and registered AR/R outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_state <= RD_IDLE;
         r_lat_cnt  <= '0;
         r_rd_beat  <= '0;
         r_rd_idx   <= '0;
         r_rd_ok    <= 1'b0;
         ar_ready   <= 1'b1;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_data     <= '0;
      end else begin
         r_rd_state <= w_rd_state_nxt;
         r_lat_cnt  <= w_lat_nxt;
         r_rd_beat  <= w_rd_beat_nxt;
         if (w_ar_hs) begin
            r_rd_idx <= w_ar_off[DEPTH_LOG2+2:3];
            r_rd_ok  <= w_ar_ok;
         end
         ar_ready <= (w_rd_state_nxt == RD_IDLE);
         r_valid  <= (w_rd_state_nxt == RD_SEND);
         if (w_rd_load) begin
            r_data <= w_rd_word;
            r_last <= (w_ld_beat == BEAT_W'(BEATS - 1));
         end else if (w_rd_state_nxt != RD_SEND) begin
            r_last <= 1'b0;
         end
      end
   end

   // Write-side state and registered AW/W handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_state <= WR_IDLE;
         r_wr_beat  <= '0;
         r_wr_idx   <= '0;
         r_wr_ok    <= 1'b0;
         aw_ready   <= 1'b1;
         w_ready    <= 1'b0;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         r_wr_beat  <= w_wr_beat_nxt;
         if (w_aw_hs) begin
            r_wr_idx <= w_aw_off[DEPTH_LOG2+2:3];
            r_wr_ok  <= w_aw_ok;
         end
         aw_ready <= (w_wr_state_nxt == WR_IDLE);
         w_ready  <= (w_wr_state_nxt == WR_DATA);
      end
   end

   // Sticky out-of-range flag, set at either address handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_err <= 1'b0;
      end else if ((w_ar_hs && !w_ar_ok) || (w_aw_hs && !w_aw_ok)) begin
         addr_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for the AXI burst memory slave.
module tb_axi_burst_mem_slave;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned BEATS  = 4;
   localparam int          RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] ar_addr = '0;
   logic              ar_valid = 1'b0;
   logic              ar_ready;
   logic              r_valid;
   logic              r_ready = 1'b0;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] aw_addr = '0;
   logic              aw_valid = 1'b0;
   logic              aw_ready;
   logic [DATA_W-1:0] w_data = '0;
   logic              w_valid = 1'b0;
   logic              w_ready;
   logic              r_last;
   logic              addr_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_rhs    = 0;

   logic [DATA_W:0]   sb_q [$];
   logic [DATA_W-1:0] exp_beats [BEATS];
   logic [DATA_W-1:0] wr_beats  [BEATS];

   always #5 clk = ~clk;

   axi_burst_mem_slave u_dut (
      .clk      (clk),
      .rst      (rst),
      .ar_addr  (ar_addr),
      .ar_valid (ar_valid),
      .ar_ready (ar_ready),
      .r_valid  (r_valid),
      .r_ready  (r_ready),
      .r_data   (r_data),
      .aw_addr  (aw_addr),
      .aw_valid (aw_valid),
      .aw_ready (aw_ready),
      .w_data   (w_data),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .r_last   (r_last),
      .addr_err (addr_err)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every accepted read beat is compared against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && r_valid && r_ready) begin
         n_rhs++;
         check_val("sb_pending", 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) begin
            logic [DATA_W:0] e;
            e = sb_q.pop_front();
            check_val("r_data", r_data, e[DATA_W-1:0]);
            check_val("r_last", 64'(r_last), 64'(e[DATA_W]));
         end
      end
   end

   task automatic push_expected();
      for (int k = 0; k < BEATS; k++)
         sb_q.push_back({(k == BEATS - 1), exp_beats[k]});
   endtask

   task automatic write_burst(input logic [ADDR_W-1:0] addr);
      int t;
      aw_addr  = addr;
      aw_valid = 1'b1;
      t = 0;
      while (!aw_ready && t < 20) begin step(); t++; end
      check_val("aw_ready_wait", 64'(aw_ready), 64'd1);
      step();
      aw_valid = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         w_data  = wr_beats[k];
         w_valid = 1'b1;
         t = 0;
         while (!w_ready && t < 20) begin step(); t++; end
         check_val("w_ready_wait", 64'(w_ready), 64'd1);
         step();
      end
      w_valid = 1'b0;
      check_val("w_ready_idle", 64'(w_ready), 64'd0);
   endtask

   // Issue one read, check latency, apply a ready pattern, check stalls and end state.
   task automatic read_burst(input logic [ADDR_W-1:0] addr, input logic [15:0] pat,
                             input int exp_cyc);
      int t, lat, cyc, start_hs;
      logic              prev_stall;
      logic [DATA_W-1:0] prev_d;
      r_ready  = 1'b0;
      ar_addr  = addr;
      ar_valid = 1'b1;
      t = 0;
      while (!ar_ready && t < 20) begin step(); t++; end
      check_val("ar_ready_wait", 64'(ar_ready), 64'd1);
      push_expected();
      start_hs = n_rhs;
      step();
      ar_valid = 1'b0;
      lat = 0;
      while (!r_valid && lat < 20) begin step(); lat++; end
      check_val("rd_latency", 64'(lat), 64'(RD_LAT));
      cyc = 0;
      prev_stall = 1'b0;
      prev_d = '0;
      while ((n_rhs - start_hs) < BEATS && cyc < 50) begin
         if (prev_stall) begin
            check_val("stall_valid", 64'(r_valid), 64'd1);
            check_val("stall_data", r_data, prev_d);
         end
         check_val("ar_ready_busy", 64'(ar_ready), 64'd0);
         r_ready    = (cyc < 16) ? pat[cyc] : 1'b1;
         prev_stall = r_valid && !r_ready;
         prev_d     = r_data;
         step();
         cyc++;
      end
      r_ready = 1'b0;
      check_val("burst_cycles", 64'(cyc), 64'(exp_cyc));
      check_val("handshakes", 64'(n_rhs - start_hs), 64'(BEATS));
      check_val("ar_ready_done", 64'(ar_ready), 64'd1);
      check_val("r_valid_done", 64'(r_valid), 64'd0);
      step();
   endtask

   initial begin
      int t, start_hs;

      // Reset state.
      step();
      step();
      check_val("rst_ar_ready", 64'(ar_ready), 64'd1);
      check_val("rst_aw_ready", 64'(aw_ready), 64'd1);
      check_val("rst_r_valid",  64'(r_valid),  64'd0);
      check_val("rst_r_last",   64'(r_last),   64'd0);
      check_val("rst_w_ready",  64'(w_ready),  64'd0);
      check_val("rst_r_data",   r_data,        64'd0);
      check_val("rst_addr_err", 64'(addr_err), 64'd0);
      rst = 1'b0;
      step();

      // W beats without AW are not accepted.
      w_valid = 1'b1;
      w_data  = 64'hDEAD;
      step();
      check_val("w_no_aw", 64'(w_ready), 64'd0);
      w_valid = 1'b0;

      // 1: aligned write then read.
      wr_beats = '{64'h11, 64'h22, 64'h33, 64'h44};
      write_burst(32'h8000_0040);
      exp_beats = '{64'h11, 64'h22, 64'h33, 64'h44};
      read_burst(32'h8000_0040, 16'hFFFF, 4);

      // 2: wrapping read, critical word first.
      exp_beats = '{64'h33, 64'h44, 64'h11, 64'h22};
      read_burst(32'h8000_0050, 16'hFFFF, 4);

      // 3: backpressure 1,0,0,1,1,0,1.
      read_burst(32'h8000_0050, 16'b0000_0000_0101_1001, 7);

      // 4: AR and AW together; each write beat lands as the matching read beat loads.
      exp_beats = '{64'hAA, 64'hBB, 64'hCC, 64'hDD};
      wr_beats  = '{64'hAA, 64'hBB, 64'hCC, 64'hDD};
      check_val("c_ar_ready", 64'(ar_ready), 64'd1);
      check_val("c_aw_ready", 64'(aw_ready), 64'd1);
      push_expected();
      start_hs = n_rhs;
      ar_addr  = 32'h8000_0040;
      aw_addr  = 32'h8000_0040;
      ar_valid = 1'b1;
      aw_valid = 1'b1;
      step();
      ar_valid = 1'b0;
      aw_valid = 1'b0;
      r_ready  = 1'b1;
      step();
      for (int k = 0; k < BEATS; k++) begin
         w_data  = wr_beats[k];
         w_valid = 1'b1;
         step();
         if (k == 0) check_val("c_first_beat", r_data, 64'hAA);
      end
      w_valid = 1'b0;
      t = 0;
      while ((n_rhs - start_hs) < BEATS && t < 20) begin step(); t++; end
      check_val("c_handshakes", 64'(n_rhs - start_hs), 64'(BEATS));
      r_ready = 1'b0;
      step();

      // 5: out-of-range read returns zeros and sets the sticky flag.
      exp_beats = '{64'h0, 64'h0, 64'h0, 64'h0};
      read_burst(32'h0000_1000, 16'hFFFF, 4);
      check_val("oor_addr_err", 64'(addr_err), 64'd1);
      // Out-of-range write aliasing a valid word index must be dropped.
      wr_beats = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};
      write_burst(32'h0000_0040);
      exp_beats = '{64'hAA, 64'hBB, 64'hCC, 64'hDD};
      read_burst(32'h8000_0040, 16'hFFFF, 4);
      check_val("sticky_addr_err", 64'(addr_err), 64'd1);

      // 6: reset after two of four beats.
      push_expected();
      start_hs = n_rhs;
      ar_addr  = 32'h8000_0040;
      ar_valid = 1'b1;
      step();
      ar_valid = 1'b0;
      r_ready  = 1'b1;
      t = 0;
      while ((n_rhs - start_hs) < 2 && t < 20) begin step(); t++; end
      check_val("mid_two_beats", 64'(n_rhs - start_hs), 64'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb_q.delete();
      check_val("mid_r_valid",  64'(r_valid),  64'd0);
      check_val("mid_ar_ready", 64'(ar_ready), 64'd1);
      check_val("mid_addr_err", 64'(addr_err), 64'd0);
      step();
      step();
      check_val("mid_no_beats", 64'(n_rhs - start_hs), 64'd2);
      r_ready = 1'b0;
      read_burst(32'h8000_0040, 16'hFFFF, 4);

      check_val("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
